// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES definitions: GF(2^8) reduction constant, the
//                MixColumns engine state type and the finite-field helpers
//                used by the column mixer.
//  Revision    : 1.0  initial release
// ============================================================================
package aes_pkg;

  // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1 (0x11B).
  localparam logic [7:0] AES_POLY = 8'h1B;

  // MixColumns engine control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mc_state_e;

  // Multiply by x in GF(2^8).
  function automatic logic [7:0] gf_xtime(input logic [7:0] x);
    gf_xtime = {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  // Multiply by a small constant (MixColumns uses 1, 2, 3, 9, B, D, E).
  // With a constant c this reduces to a fixed XOR network.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] acc;
    logic [7:0] pw;
    acc = 8'h00;
    pw  = a;
    for (int i = 0; i < 4; i++) begin
      if (c[i]) acc = acc ^ pw;
      pw = gf_xtime(pw);
    end
    gf_mul = acc;
  endfunction

endpackage : aes_pkg
`default_nettype wire

// File: rtl/aes_mixcol_word.sv
`default_nettype none
// ============================================================================
//  Module      : aes_mixcol_word
//  Description : Combinational mixer for one 32-bit AES state column.
//                Forward {02,03,01,01}, inverse {0E,0B,0D,09}, or bypass.
//  Ports       : col_i    [31:0] input column, b0 = [31:24] .. b3 = [7:0]
//                inv_i           1 = inverse MixColumns
//                bypass_i        1 = pass column through (overrides inv_i)
//                col_o    [31:0] mixed column, same byte layout
//  Revision    : 1.0  initial release
// ============================================================================
module aes_mixcol_word
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  input  logic        inv_i,
  input  logic        bypass_i,
  output logic [31:0] col_o
);

  logic [7:0] b   [4];
  logic [7:0] h   [4];
  logic [3:0] coef[4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      b[i] = col_i[31-8*i -: 8];
    end

    // First row of the circulant matrix; later rows are rotations of it.
    if (inv_i) begin
      coef[0] = 4'hE; coef[1] = 4'hB; coef[2] = 4'hD; coef[3] = 4'h9;
    end else begin
      coef[0] = 4'h2; coef[1] = 4'h3; coef[2] = 4'h1; coef[3] = 4'h1;
    end

    // h[r] = sum_j coef[(j - r) mod 4] * b[j]
    for (int r = 0; r < 4; r++) begin
      h[r] = 8'h00;
      for (int j = 0; j < 4; j++) begin
        h[r] = h[r] ^ gf_mul(b[j], coef[(j - r + 4) % 4]);
      end
    end

    col_o = bypass_i ? col_i : {h[0], h[1], h[2], h[3]};
  end

endmodule : aes_mixcol_word
`default_nettype wire

// File: rtl/aes_mixcolumns_engine.sv
`default_nettype none
// ============================================================================
//  Module      : aes_mixcolumns_engine
//  Description : Handshaked AES MixColumns / InvMixColumns / bypass unit.
//                Processes LANES columns per beat over 4/LANES beats.
//  Ports       : clk_i, rst_i           clock, synchronous active-high reset
//                in_valid_i/in_ready_o  input handshake
//                in_data_i  [127:0]     state, column i = [i*32 +: 32]
//                in_inv_i               1 = inverse mix (latched per block)
//                in_bypass_i            1 = no mix (latched per block)
//                out_valid_o/out_ready_i output handshake
//                out_data_o [127:0]     result state
//                busy_o                 block in flight or awaiting pickup
//  Revision    : 1.0  initial release
// ============================================================================
module aes_mixcolumns_engine
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] in_data_i,
  input  logic         in_inv_i,
  input  logic         in_bypass_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] out_data_o,
  output logic         busy_o
);

  localparam int N  = (LANES == 1) ? 4 : (LANES == 2) ? 2 : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("aes_mixcolumns_engine: LANES must be 1, 2 or 4");
  end

  mc_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [127:0]    work_q, work_d;
  logic            inv_q, inv_d;
  logic            byp_q, byp_d;
  logic [127:0]    res_q, res_d;
  logic            out_valid_q;
  logic            busy_q;

  logic [31:0]     lane_in [LANES];
  logic [31:0]     lane_out[LANES];
  logic            accept;
  logic            last_beat;

  assign in_ready_o  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready_i);
  assign accept      = in_valid_i && in_ready_o;
  assign last_beat   = (cnt_q == CW'(N - 1));
  assign out_valid_o = out_valid_q;
  assign out_data_o  = res_q;
  assign busy_o      = busy_q;

  // Select the working columns for the current beat.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = 32'h0;
      for (int k = 0; k < N; k++) begin
        if (cnt_q == CW'(k)) lane_in[l] = work_q[(k*LANES + l)*32 +: 32];
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_mixcol_word u_word (
      .col_i    (lane_in[g]),
      .inv_i    (inv_q),
      .bypass_i (byp_q),
      .col_o    (lane_out[g])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    inv_d   = inv_q;
    byp_d   = byp_q;
    res_d   = res_q;

    case (state_q)
      ST_IDLE: ;
      ST_BUSY: begin
        // Each lane result lands back in the same column slot it came from.
        for (int k = 0; k < N; k++) begin
          if (cnt_q == CW'(k)) begin
            for (int l = 0; l < LANES; l++) begin
              res_d[(k*LANES + l)*32 +: 32] = lane_out[l];
            end
          end
        end
        if (last_beat) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Acceptance covers both IDLE and the back-to-back case from DONE.
    if (accept) begin
      work_d  = in_data_i;
      inv_d   = in_inv_i;
      byp_d   = in_bypass_i;
      cnt_d   = '0;
      state_d = ST_BUSY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      work_q      <= 128'h0;
      inv_q       <= 1'b0;
      byp_q       <= 1'b0;
      res_q       <= 128'h0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      inv_q       <= inv_d;
      byp_q       <= byp_d;
      res_q       <= res_d;
      out_valid_q <= (state_d == ST_DONE);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

endmodule : aes_mixcolumns_engine
`default_nettype wire

// File: doc/aes_mixcolumns_engine.md
# aes_mixcolumns_engine

Parametrised, handshaked MixColumns unit for the AES datapath. It supports forward and inverse MixColumns, plus a bypass for the final round, selected per block. It processes a 128-bit state `LANES` columns per cycle over `4/LANES` beats, so area can be traded against throughput. It sits between ShiftRows/InvShiftRows and AddRoundKey in both the encrypt and decrypt round pipelines, and replaces the fixed combinational inverse-only column mixer.

## Interface
- `LANES`, default 4: columns processed per cycle; legal values 1, 2, 4; any other value is an elaboration error.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input block valid.
- `in_ready`  out  1  engine can accept a block this cycle.
- `in_data`  in  128  state; column i = `in_data[i*32 +: 32]`; within a column, byte b0 = [31:24] … b3 = [7:0].
- `in_inv`  in  1  0 = forward MixColumns {02,03,01,01}; 1 = inverse {0E,0B,0D,09}.
- `in_bypass`  in  1  1 = pass the state through unmixed (AES last round); overrides `in_inv`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  128  mixed state, same column/byte layout as `in_data`.
- `busy`  out  1  high in BUSY or DONE.

## Operation
- Beat count N = 4/LANES. A beat counter of width max(1, log2 N) counts 0..N-1.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`: capture `in_data`, `in_inv`, `in_bypass` into work registers, clear the counter, go to BUSY.
  - BUSY: each cycle, beat k transforms columns k*LANES .. k*LANES+LANES-1 and writes them into the result register; the counter increments. On beat N-1, go to DONE.
  - DONE: `out_valid`=1; `out_data` and the result register are held stable until `out_ready`. On `out_ready`: if `in_valid` is also high, capture the new block and go to BUSY (back-to-back); otherwise go to IDLE.
- `in_ready` = (IDLE) or (DONE and `out_ready`).
- Mode and bypass are latched per block at acceptance. Changes on `in_inv`/`in_bypass` while a block is in flight have no effect.
- Arithmetic is GF(2^8) with polynomial 0x11B; xtime(x) = (x<<1) ^ (x[7] ? 8'h1B : 0).
  - Forward: h0 = 2b0^3b1^b2^b3, rotating.
  - Inverse: h0 = Eb0^Bb1^Db2^9b3, rotating.
- Bypass takes the same N-cycle latency as the other modes; latency is uniform.
- No column reordering: output column i is always derived from input column i only.

## Timing
- Reset (synchronous, `rst` high at a rising edge): state = IDLE, counter = 0, `out_valid` = 0, `out_data` = 128'h0, `busy` = 0, `in_ready` = 1 from the first cycle after reset. Reset wins over every simultaneous event, including an in-flight block, which is discarded.
- Latency: block accepted at edge E; `out_valid` rises after edge E+N. So LANES=4 gives 1 cycle, 2 gives 2, 1 gives 4.
- Throughput with `out_ready` held high: one block per N+1 cycles (DONE overlaps the next acceptance).
- Backpressure: `out_ready` low in DONE holds `out_valid`=1 and `out_data` constant indefinitely; `in_ready` = 0.
- `in_valid` while in BUSY is ignored (`in_ready`=0); the source must hold it.
- All outputs are registered except `in_ready`, which is combinational from state and `out_ready`.

## Structure
- A shared package `aes_pkg` holds `AES_POLY` (8'h1B) and the functions `gf_xtime`, `gf_mul` (constant multipliers 2, 3, 9, B, D, E).
- A sub-module `aes_mixcol_word` handles one 32-bit column: inputs `col`, `inv`, `bypass`; output the mixed column; purely combinational. The engine instantiates `LANES` copies, muxes the working columns in by beat index, and demuxes the results into the result register.

## Test plan
- Forward, each LANES in {1,2,4}: `in_data` = c6c6c6c6_01010101_f20a225c_db135345, `in_inv`=0 -> `out_data` = c6c6c6c6_01010101_9fdc589d_8e4da1bc after exactly N cycles.
- Inverse round-trip: feed c6c6c6c6_01010101_9fdc589d_8e4da1bc with `in_inv`=1 -> c6c6c6c6_01010101_f20a225c_db135345. Also column 4d7ebdf8 -> 2d26314c and d5d5d7d6 -> d4d4d4d5.
- Bypass: `in_bypass`=1, `in_inv`=1, arbitrary data -> output equals input after N cycles.
- Backpressure/back-to-back: hold `out_ready`=0 for 5 cycles in DONE -> `out_valid` and data stable, `in_ready`=0. Then assert `out_ready` with `in_valid` -> next block accepted the same cycle, with no IDLE cycle in between.
- Reset mid-operation, LANES=1: assert `rst` at beat 2 -> next cycle state IDLE, `out_valid`=0, `out_data`=0. A fresh block afterwards completes correctly in 4 cycles.
- Mode latch: toggle `in_inv` during BUSY -> result matches the mode captured at acceptance. Random 1000-block comparison against a reference model, all modes and all LANES values.
